// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state encoding and stream framing sizes.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [2:0] HDR_BYTES  = 3'd2;
  localparam logic [2:0] WORD_BYTES = 3'd4;

endpackage

// File: rtl/byte_packer.sv
// MSB-first byte shift register; word_full marks the shift that completes
// a group of nbytes, after which the byte counter restarts.
module byte_packer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        shift,
  input  logic [2:0]  nbytes,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);

  logic [2:0] cnt;

  assign word_full = shift && (cnt == nbytes - 3'd1);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt  <= 3'd0;
      word <= 32'd0;
    end else begin
      if (clr)
        cnt <= 3'd0;
      else if (shift)
        cnt <= word_full ? 3'd0 : cnt + 3'd1;
      if (shift)
        word <= {word[23:0], din};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a counted, big-endian program into the instruction
// memory while stalling the CPU, then returns the address port to fetch.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_SIZE = 128
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [31:0] cpu_pc,
  output logic [31:0] im_pc,
  output logic [31:0] im_wdata,
  output logic        im_we,
  output logic        cpu_run,
  output logic        busy,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int AW =
    ($clog2(IMEM_SIZE) + 2 < 8) ? 8 : $clog2(IMEM_SIZE) + 2;

  state_e        state, state_n;
  logic [15:0]   count;
  logic [AW-1:0] addr;
  logic [31:0]   pk_word;
  logic          pk_full;
  logic          accept;
  logic          start;
  logic [15:0]   hdr;
  logic          hdr_ok;
  logic          last_word;

  assign accept    = in_valid && in_ready;
  assign start     = load_start &&
                     (state inside {S_IDLE, S_DONE, S_ERR});
  // header is decided on the second byte, before it lands in the packer
  assign hdr       = {pk_word[7:0], in_data};
  assign hdr_ok    = (hdr != 16'd0) && (hdr <= 16'(IMEM_SIZE));
  assign last_word = (words_loaded + 16'd1 == count);

  assign im_wdata = pk_word;
  assign im_pc    = busy ? 32'(addr) : cpu_pc;

  byte_packer u_pack (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (start),
    .shift     (accept),
    .nbytes    ((state == S_HDR) ? HDR_BYTES : WORD_BYTES),
    .din       (in_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start) state_n = S_HDR;
      S_HDR:
        if (pk_full) state_n = hdr_ok ? S_DATA : S_ERR;
      S_DATA:
        if (pk_full) state_n = S_WRITE;
      S_WRITE:
        state_n = last_word ? S_DONE : S_DATA;
      S_DONE, S_ERR:
        if (start) state_n = S_HDR;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      im_we        <= 1'b0;
      cpu_run      <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
      count        <= 16'd0;
      addr         <= '0;
    end else begin
      state    <= state_n;
      busy     <= state_n inside {S_HDR, S_DATA, S_WRITE};
      in_ready <= state_n inside {S_HDR, S_DATA};
      im_we    <= (state_n == S_WRITE);
      cpu_run  <= (state_n == S_DONE);
      error    <= (state_n == S_ERR);
      if (start)
        words_loaded <= 16'd0;
      if (state == S_HDR && pk_full) begin
        count <= hdr;
        if (hdr_ok) begin
          words_loaded <= 16'd0;
          addr         <= '0;
        end
      end
      if (state == S_WRITE) begin
        addr         <= addr + AW'(4);
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized program streams against a reference
// of expected writes (word k of the program lands at byte address 4*k).
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic [31:0] cpu_pc = 32'd0;
  logic [31:0] im_pc;
  logic [31:0] im_wdata;
  logic        im_we;
  logic        cpu_run;
  logic        busy;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(.IMEM_SIZE(128)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .load_start   (load_start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .cpu_pc       (cpu_pc),
    .im_pc        (im_pc),
    .im_wdata     (im_wdata),
    .im_we        (im_we),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  always @(negedge CLK) begin
    if (im_we) begin
      wa.push_back(im_pc);
      wd.push_back(im_wdata);
    end
  end

  int checks = 0;
  int errors = 0;
  int first_cyc = 0;

  task automatic mk_stream(input logic [31:0] w[$], input logic [15:0] n,
                           output logic [7:0] s[$]);
    s = {};
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    foreach (w[k])
      for (int j = 3; j >= 0; j--) s.push_back(w[k][8*j +: 8]);
  endtask

  // mode 0: valid held, 1: valid every other cycle, 2: random valid
  task automatic send(input logic [7:0] s[$], input int mode,
                      input int lo, input int hi);
    int   i;
    int   g;
    logic v;
    i = lo;
    g = 0;
    while (i <= hi && g < 4000) begin
      @(negedge CLK);
      case (mode)
        0:       v = 1'b1;
        1:       v = (g % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? s[i] : 8'($urandom);
      if (v && in_ready) begin
        if (i == 0) first_cyc = cyc;
        i++;
      end
      g++;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    checks++;
    if (i != hi + 1) begin
      errors++;
      $display("FAIL send_bound sent %0d want %0d", i - lo, hi - lo + 1);
    end
  endtask

  task automatic start_pulse;
    @(negedge CLK);
    load_start = 1'b1;
    @(negedge CLK);
    load_start = 1'b0;
  endtask

  task automatic wait_run(output int c);
    int n;
    n = 0;
    while (!cpu_run && !error && n < 50) begin
      @(negedge CLK);
      n++;
    end
    c = cyc;
  endtask

  task automatic test_reset;
    RST    = 1'b0;
    cpu_pc = 32'h10;
    repeat (2) @(negedge CLK);
    checks++;
    if (im_pc !== 32'h10) begin
      errors++; $display("FAIL rst_im_pc got %h want 10", im_pc);
    end
    checks++;
    if ({cpu_run, im_we, in_ready, busy, error} !== 5'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 00000",
               {cpu_run, im_we, in_ready, busy, error});
    end
    checks++;
    if (words_loaded !== 16'd0 || im_wdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_regs got wl=%0d wdata=%h want 0 0",
               words_loaded, im_wdata);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_nominal;
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int          base;
    int          c;
    w = {32'h20080005, 32'hAC080000};
    mk_stream(w, 16'd2, s);
    base = wa.size();
    cpu_pc = 32'h40;
    start_pulse();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL nom_start got busy=%b rdy=%b want 1 1", busy, in_ready);
    end
    send(s, 0, 0, s.size() - 1);
    wait_run(c);
    checks++;
    if (wa.size() - base != 2) begin
      errors++; $display("FAIL nom_nwr got %0d want 2", wa.size() - base);
    end
    for (int k = 0; k < 2 && base + k < wa.size(); k++) begin
      checks++;
      if (wa[base+k] !== 32'(4*k) || wd[base+k] !== w[k]) begin
        errors++;
        $display("FAIL nom_wr%0d got %h@%h want %h@%h", k,
                 wd[base+k], wa[base+k], w[k], 32'(4*k));
      end
    end
    checks++;
    if (c - first_cyc != 12) begin
      errors++; $display("FAIL nom_latency got %0d want 12", c - first_cyc);
    end
    checks++;
    if (cpu_run !== 1'b1 || words_loaded !== 16'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nom_done got run=%b wl=%0d busy=%b want 1 2 0",
               cpu_run, words_loaded, busy);
    end
    checks++;
    if (im_pc !== 32'h40) begin
      errors++; $display("FAIL nom_mux got %h want 40", im_pc);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int          base;
    int          c;
    w = {32'h20080005, 32'hAC080000};
    mk_stream(w, 16'd2, s);
    base = wa.size();
    start_pulse();
    send(s, 1, 0, s.size() - 1);
    wait_run(c);
    checks++;
    if (wa.size() - base != 2) begin
      errors++; $display("FAIL bp_nwr got %0d want 2", wa.size() - base);
    end
    for (int k = 0; k < 2 && base + k < wa.size(); k++) begin
      checks++;
      if (wa[base+k] !== 32'(4*k) || wd[base+k] !== w[k]) begin
        errors++;
        $display("FAIL bp_wr%0d got %h@%h want %h@%h", k,
                 wd[base+k], wa[base+k], w[k], 32'(4*k));
      end
    end
    checks++;
    if (cpu_run !== 1'b1 || words_loaded !== 16'd2) begin
      errors++;
      $display("FAIL bp_done got run=%b wl=%0d want 1 2", cpu_run, words_loaded);
    end
  endtask

  task automatic test_random;
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int          base;
    int          c;
    int          n;
    int          bad;
    for (int it = 0; it < 5; it++) begin
      n = (it == 4) ? 128 : int'($urandom_range(1, 8));
      w = {};
      for (int k = 0; k < n; k++) w.push_back($urandom);
      mk_stream(w, 16'(n), s);
      base = wa.size();
      start_pulse();
      send(s, (it == 4) ? 0 : 2, 0, s.size() - 1);
      wait_run(c);
      checks++;
      if (wa.size() - base != n) begin
        errors++;
        $display("FAIL rnd%0d_nwr got %0d want %0d", it, wa.size() - base, n);
      end
      bad = 0;
      for (int k = 0; k < n && base + k < wa.size(); k++)
        if (wa[base+k] !== 32'(4*k) || wd[base+k] !== w[k]) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL rnd%0d_wr got %0d bad writes want 0", it, bad);
      end
      checks++;
      if (cpu_run !== 1'b1 || words_loaded !== 16'(n)) begin
        errors++;
        $display("FAIL rnd%0d_done got run=%b wl=%0d want 1 %0d",
                 it, cpu_run, words_loaded, n);
      end
    end
    checks++;
    if (wa[wa.size()-1] !== 32'h1FC) begin
      errors++; $display("FAIL max_addr got %h want 1fc", wa[wa.size()-1]);
    end
  endtask

  task automatic test_illegal;
    logic [7:0] s[$];
    logic [15:0] h;
    int          base;
    start_pulse();
    for (int it = 0; it < 2; it++) begin
      h = (it == 0) ? 16'h0081 : 16'h0000;
      s = {h[15:8], h[7:0]};
      base = wa.size();
      send(s, 0, 0, 1);
      repeat (3) @(negedge CLK);
      checks++;
      if (error !== 1'b1 || cpu_run !== 1'b0 || in_ready !== 1'b0 ||
          busy !== 1'b0) begin
        errors++;
        $display("FAIL ill%0d_flags got err=%b run=%b rdy=%b busy=%b want 1 0 0 0",
                 it, error, cpu_run, in_ready, busy);
      end
      checks++;
      if (wa.size() != base) begin
        errors++; $display("FAIL ill%0d_we got %0d writes want 0", it, wa.size() - base);
      end
      start_pulse();
      checks++;
      if (error !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL ill%0d_clear got err=%b busy=%b want 0 1", it, error, busy);
      end
    end
  endtask

  task automatic test_reset_midload;
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int          base;
    int          c;
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    w = {$urandom, $urandom, $urandom};
    mk_stream(w, 16'd3, s);
    start_pulse();
    send(s, 0, 0, 7);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst got busy=%b rdy=%b wl=%0d want 0 0 0",
               busy, in_ready, words_loaded);
    end
    w = {$urandom};
    mk_stream(w, 16'd1, s);
    base = wa.size();
    start_pulse();
    send(s, 0, 0, s.size() - 1);
    wait_run(c);
    checks++;
    if (wa.size() - base != 1 || wa[wa.size()-1] !== 32'h0 ||
        wd[wd.size()-1] !== w[0]) begin
      errors++;
      $display("FAIL mid_fresh got %h@%h want %h@0",
               wd[wd.size()-1], wa[wa.size()-1], w[0]);
    end
  endtask

  task automatic test_reload;
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int          base;
    int          c;
    int          bad;
    w = {$urandom, $urandom};
    mk_stream(w, 16'd2, s);
    base = wa.size();
    start_pulse();
    checks++;
    if (cpu_run !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rl_start got run=%b busy=%b want 0 1", cpu_run, busy);
    end
    send(s, 0, 0, 7);
    start_pulse();
    checks++;
    if (words_loaded !== 16'd1 || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rl_ignore got wl=%0d rdy=%b busy=%b want 1 1 1",
               words_loaded, in_ready, busy);
    end
    send(s, 0, 8, s.size() - 1);
    wait_run(c);
    bad = 0;
    for (int k = 0; k < 2 && base + k < wa.size(); k++)
      if (wa[base+k] !== 32'(4*k) || wd[base+k] !== w[k]) bad++;
    checks++;
    if (wa.size() - base != 2 || bad != 0 || words_loaded !== 16'd2 ||
        cpu_run !== 1'b1) begin
      errors++;
      $display("FAIL rl_done got nwr=%0d bad=%0d wl=%0d run=%b want 2 0 2 1",
               wa.size() - base, bad, words_loaded, cpu_run);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_random();
    test_illegal();
    test_reset_midload();
    test_reload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
